gate_exhaustive_tester: RTL and testbench



---
 rtl/gate_tb_pkg.sv | 19 +
 rtl/gate_settle_timer.sv | 30 +++
 rtl/gate_exhaustive_tester.sv | 133 +++++++++++++
 tb/tb_gate_exhaustive_tester.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gate_tb_pkg.sv
// Shared types and helpers for the exhaustive gate test stage.
// Holds the controller state encoding and the truth-table lookup.
package gate_tb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      APPLY = 2'd1,
      CHECK = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam int MAX_N_IN = 6;

   // Expected gate output for input vector vec; tables narrower than 64 bits are zero-extended.
   function automatic logic exp_bit(input logic [63:0] tt, input logic [5:0] vec);
      return tt[vec];
   endfunction

endpackage

// File: rtl/gate_settle_timer.sv
// Settle-time down-counter: load arms it for SETTLE cycles, expire is high
// in the last cycle of the window.
module gate_settle_timer #(
   parameter int SETTLE = 1
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_load,
   input  logic i_en,
   output logic o_expire
);

   localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam logic [CW-1:0] LOAD_VAL = CW'(SETTLE - 1);

   logic [CW-1:0] r_cnt;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_cnt <= '0;
      end else if (i_load) begin
         r_cnt <= LOAD_VAL;
      end else if (i_en && (r_cnt != '0)) begin
         r_cnt <= r_cnt - 1'b1;
      end
   end

   assign o_expire = (r_cnt == '0);

endmodule

// File: rtl/gate_exhaustive_tester.sv
// Drives every input vector of a small gate in ascending order, samples the gate
// after SETTLE cycles and scores each sample against the EXP_TT truth table.
module gate_exhaustive_tester
   import gate_tb_pkg::*;
#(
   parameter int                 N_IN   = 2,
   parameter logic [2**N_IN-1:0] EXP_TT = 4'b1000,
   parameter int                 SETTLE = 1
) (
   input  logic            i_clk,
   input  logic            i_rst,
   input  logic            i_start,
   output logic [N_IN-1:0] o_dut_in,
   input  logic            i_dut_out,
   output logic            o_busy,
   output logic            o_done,
   output logic            o_pass,
   output logic [N_IN:0]   o_err_cnt,
   output logic            o_first_err_valid,
   output logic [N_IN-1:0] o_first_err_vec,
   output state_t          o_state
);

   localparam int NV = 2**N_IN;
   localparam logic [N_IN-1:0] LAST_VEC = N_IN'(NV - 1);

   state_t          r_state;
   state_t          w_next;
   logic [N_IN-1:0] r_vec;
   logic [N_IN-1:0] r_dut_in;
   logic [N_IN-1:0] r_first_err_vec;
   logic [N_IN:0]   r_err_cnt;
   logic [N_IN:0]   w_err_inc;
   logic            r_first_err_valid;
   logic            r_pass;
   logic            w_load;
   logic            w_settle_en;
   logic            w_expire;
   logic            w_mismatch;

   gate_settle_timer #(.SETTLE(SETTLE)) u_settle (
      .i_clk    (i_clk),
      .i_rst    (i_rst),
      .i_load   (w_load),
      .i_en     (w_settle_en),
      .o_expire (w_expire)
   );

   assign w_mismatch = (i_dut_out != exp_bit(64'(EXP_TT), 6'(r_vec)));
   assign w_err_inc  = r_err_cnt + {{N_IN{1'b0}}, w_mismatch};

   // Handshake: start is a level request honoured only in IDLE; done is a
   // single-cycle completion pulse and the result outputs hold until the next start.
   always_comb begin
      w_next      = r_state;
      w_load      = 1'b0;
      w_settle_en = 1'b0;
      case (r_state)
         IDLE: begin
            if (i_start) begin
               w_next = APPLY;
               w_load = 1'b1;
            end
         end
         APPLY: begin
            w_settle_en = 1'b1;
            if (w_expire) w_next = CHECK;
         end
         CHECK: begin
            if (r_vec == LAST_VEC) begin
               w_next = DONE;
            end else begin
               w_next = APPLY;
               w_load = 1'b1;
            end
         end
         DONE:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state           <= IDLE;
         r_vec             <= '0;
         r_dut_in          <= '0;
         r_err_cnt         <= '0;
         r_first_err_valid <= 1'b0;
         r_first_err_vec   <= '0;
         r_pass            <= 1'b0;
      end else begin
         r_state <= w_next;
         case (r_state)
            IDLE: begin
               if (i_start) begin
                  r_vec             <= '0;
                  r_dut_in          <= '0;
                  r_err_cnt         <= '0;
                  r_first_err_valid <= 1'b0;
                  r_first_err_vec   <= '0;
                  r_pass            <= 1'b0;
               end
            end
            CHECK: begin
               r_err_cnt <= w_err_inc;
               if (w_mismatch && !r_first_err_valid) begin
                  r_first_err_valid <= 1'b1;
                  r_first_err_vec   <= r_vec;
               end
               // Terminal compare precedes the increment, so vec never wraps.
               if (r_vec == LAST_VEC) begin
                  r_pass <= (w_err_inc == '0);
               end else begin
                  r_vec    <= r_vec + 1'b1;
                  r_dut_in <= r_vec + 1'b1;
               end
            end
            DONE:    r_dut_in <= '0;
            default: ;
         endcase
      end
   end

   assign o_dut_in          = r_dut_in;
   assign o_busy            = (r_state != IDLE);
   assign o_done            = (r_state == DONE);
   assign o_pass            = r_pass;
   assign o_err_cnt         = r_err_cnt;
   assign o_first_err_valid = r_first_err_valid;
   assign o_first_err_vec   = r_first_err_vec;
   assign o_state           = r_state;

endmodule

// File: tb/tb_gate_exhaustive_tester.sv
// Bench for gate_exhaustive_tester: a default AND2 instance and a 3-input
// AND instance with SETTLE=3, checked every cycle against a timeline model.
module tb_gate_exhaustive_tester;
   import gate_tb_pkg::*;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;
   logic start0, start1;
   int   gsel0, gsel1;   // 0 AND, 1 OR, 2 tied 1, 3 tied 0

   logic [1:0] dut_in0;  logic dut_out0, busy0, done0, pass0, fev0;
   logic [2:0] err0;     logic [1:0] fvec0;  state_t st0;
   logic [2:0] dut_in1;  logic dut_out1, busy1, done1, pass1, fev1;
   logic [3:0] err1;     logic [2:0] fvec1;  state_t st1;

   gate_exhaustive_tester u_dut0 (
      .i_clk(clk), .i_rst(rst), .i_start(start0), .o_dut_in(dut_in0), .i_dut_out(dut_out0),
      .o_busy(busy0), .o_done(done0), .o_pass(pass0), .o_err_cnt(err0),
      .o_first_err_valid(fev0), .o_first_err_vec(fvec0), .o_state(st0));

   gate_exhaustive_tester #(.N_IN(3), .EXP_TT(8'h80), .SETTLE(3)) u_dut1 (
      .i_clk(clk), .i_rst(rst), .i_start(start1), .o_dut_in(dut_in1), .i_dut_out(dut_out1),
      .o_busy(busy1), .o_done(done1), .o_pass(pass1), .o_err_cnt(err1),
      .o_first_err_valid(fev1), .o_first_err_vec(fvec1), .o_state(st1));

   // Gate under test, modelled by the bench.
   function automatic logic gate_fn(input int sel, input int nin, input int v);
      case (sel)
         0:       return (v == (1 << nin) - 1);
         1:       return (v != 0);
         2:       return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   always_comb begin
      dut_out0 = gate_fn(gsel0, 2, int'(dut_in0));
      dut_out1 = gate_fn(gsel1, 3, int'(dut_in1));
   end

   // ---------------- scoreboard bookkeeping ----------------
   int n_checks = 0;
   int n_errs   = 0;
   bit chk_en   = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errs++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- timeline model ----------------
   // A run is a count t of edges since start was taken; vector k occupies
   // t in [k*P, k*P+P-1] with P = SETTLE+1, and t = NV*P is the done cycle.
   function automatic int nin_of(input int i); return (i == 0) ? 2 : 3; endfunction
   function automatic int nv_of(input int i);  return (i == 0) ? 4 : 8; endfunction
   function automatic int per_of(input int i); return (i == 0) ? 2 : 4; endfunction
   function automatic logic [7:0] tt_of(input int i); return (i == 0) ? 8'h08 : 8'h80; endfunction

   int m_t[2];
   bit m_run[2];
   int m_err[2];
   bit m_fev[2];
   int m_fvec[2];
   bit m_pass[2];

   always @(posedge clk) begin
      int nv, per, k, sel;
      logic s;
      logic [7:0] ttv;
      for (int i = 0; i < 2; i++) begin
         nv  = nv_of(i);
         per = per_of(i);
         ttv = tt_of(i);
         s   = (i == 0) ? start0 : start1;
         sel = (i == 0) ? gsel0 : gsel1;
         if (rst) begin
            m_run[i] = 0; m_t[i] = 0; m_err[i] = 0; m_fev[i] = 0; m_fvec[i] = 0; m_pass[i] = 0;
         end else if (m_run[i]) begin
            if (m_t[i] == nv * per) begin
               m_run[i] = 0;
            end else begin
               if ((m_t[i] % per) == per - 1) begin
                  k = m_t[i] / per;
                  if (gate_fn(sel, nin_of(i), k) != ttv[k]) begin
                     m_err[i]++;
                     if (!m_fev[i]) begin m_fev[i] = 1; m_fvec[i] = k; end
                  end
                  if (k == nv - 1) m_pass[i] = (m_err[i] == 0);
               end
               m_t[i]++;
            end
         end else if (s) begin
            m_run[i] = 1; m_t[i] = 0; m_err[i] = 0; m_fev[i] = 0; m_fvec[i] = 0; m_pass[i] = 0;
         end
      end
   end

   // Per-cycle compare of both instances against the model.
   always @(negedge clk) begin
      logic [31:0] e_done, e_din;
      int nv, per;
      if (chk_en) begin
         for (int i = 0; i < 2; i++) begin
            nv     = nv_of(i);
            per    = per_of(i);
            e_done = 32'(m_run[i] && (m_t[i] == nv * per));
            e_din  = !m_run[i] ? 0 : (e_done != 0) ? 32'(nv - 1) : 32'(m_t[i] / per);
            chk($sformatf("i%0d busy", i),  (i == 0) ? 32'(busy0) : 32'(busy1), 32'(m_run[i]));
            chk($sformatf("i%0d done", i),  (i == 0) ? 32'(done0) : 32'(done1), e_done);
            chk($sformatf("i%0d dut_in", i),(i == 0) ? 32'(dut_in0) : 32'(dut_in1), e_din);
            chk($sformatf("i%0d err_cnt", i),(i == 0) ? 32'(err0) : 32'(err1), 32'(m_err[i]));
            chk($sformatf("i%0d first_err_valid", i), (i == 0) ? 32'(fev0) : 32'(fev1), 32'(m_fev[i]));
            chk($sformatf("i%0d first_err_vec", i), (i == 0) ? 32'(fvec0) : 32'(fvec1), 32'(m_fvec[i]));
            chk($sformatf("i%0d pass", i),  (i == 0) ? 32'(pass0) : 32'(pass1), 32'(m_pass[i]));
         end
      end
   end

   // ---------------- driver tasks ----------------
   logic [31:0] cap_err, cap_pass, cap_fev, cap_fvec;

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic set_start(input int i, input logic v);
      if (i == 0) start0 = v; else start1 = v;
   endtask

   // Launches a run; cyc is the number of edges from the start edge up to the
   // done cycle (the start edge counts as the first). Results captured at done.
   task automatic run(input int i, input int budget, input bit chk_clr, output int cyc);
      set_start(i, 1'b1);
      tick();
      set_start(i, 1'b0);
      cyc = 1;
      forever begin
         @(negedge clk);
         if (chk_clr && cyc == 1) begin
            chk("clear on start err_cnt", (i == 0) ? 32'(err0) : 32'(err1), 0);
            chk("clear on start first_err_valid", (i == 0) ? 32'(fev0) : 32'(fev1), 0);
         end
         if ((i == 0) ? done0 : done1) begin
            cap_err  = (i == 0) ? 32'(err0)  : 32'(err1);
            cap_pass = (i == 0) ? 32'(pass0) : 32'(pass1);
            cap_fev  = (i == 0) ? 32'(fev0)  : 32'(fev1);
            cap_fvec = (i == 0) ? 32'(fvec0) : 32'(fvec1);
            break;
         end
         if (cyc >= budget) break;
         tick();
         cyc++;
      end
      tick();
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int cyc, ndone, nidle;
      int done_q[$];
      int exp_q[$];

      rst = 1'b1; start0 = 1'b0; start1 = 1'b0; gsel0 = 0; gsel1 = 0;
      tick();
      chk_en = 1;
      @(negedge clk);
      chk("reset busy", 32'(busy0), 0);
      chk("reset dut_in", 32'(dut_in0), 0);
      chk("reset err_cnt", 32'(err0), 0);
      chk("reset pass", 32'(pass0), 0);
      tick();
      rst = 1'b0;
      tick();

      // 1: AND2 matches the default table
      gsel0 = 0;
      run(0, 40, 1'b0, cyc);
      chk("t1 done cycle", cyc, 9);
      chk("t1 pass", cap_pass, 1);
      chk("t1 err_cnt", cap_err, 0);
      chk("t1 first_err_valid", cap_fev, 0);

      // 2: OR2 fails at vectors 1 and 2
      gsel0 = 1;
      run(0, 40, 1'b0, cyc);
      chk("t2 err_cnt", cap_err, 2);
      chk("t2 first_err_vec", cap_fvec, 1);
      chk("t2 first_err_valid", cap_fev, 1);
      chk("t2 pass", cap_pass, 0);

      // 3: output stuck at 1, then a clean rerun clears the history
      gsel0 = 2;
      run(0, 40, 1'b0, cyc);
      chk("t3 err_cnt", cap_err, 3);
      chk("t3 first_err_vec", cap_fvec, 0);
      chk("t3 pass", cap_pass, 0);
      gsel0 = 0;
      run(0, 40, 1'b1, cyc);
      chk("t3b pass", cap_pass, 1);
      chk("t3b err_cnt", cap_err, 0);

      // 4: reset in the middle of an OR2 run
      gsel0 = 1;
      set_start(0, 1'b1);
      tick();
      set_start(0, 1'b0);
      repeat (4) tick();
      @(negedge clk);
      chk("t4 err_cnt before reset", 32'(err0), 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      @(negedge clk);
      chk("t4 busy after reset", 32'(busy0), 0);
      chk("t4 dut_in after reset", 32'(dut_in0), 0);
      chk("t4 err_cnt after reset", 32'(err0), 0);
      chk("t4 pass after reset", 32'(pass0), 0);
      ndone = 0;
      for (int c = 0; c < 12; c++) begin
         tick();
         @(negedge clk);
         if (done0) ndone++;
      end
      chk("t4 no done after abort", ndone, 0);
      tick();
      gsel0 = 0;
      run(0, 40, 1'b0, cyc);
      chk("t4 full run cycle", cyc, 9);
      chk("t4 full run pass", cap_pass, 1);

      // 5a: start held high -> back-to-back runs with one idle cycle
      set_start(0, 1'b1);
      nidle = 0;
      for (int c = 1; c <= 29; c++) begin
         tick();
         @(negedge clk);
         if (done0) done_q.push_back(c);
         if (!busy0) nidle++;
      end
      tick();
      set_start(0, 1'b0);
      exp_q = '{9, 19, 29};
      chk("t5 done count", done_q.size(), exp_q.size());
      while (done_q.size() > 0 && exp_q.size() > 0)
         chk("t5 done cycle", done_q.pop_front(), exp_q.pop_front());
      chk("t5 idle cycles between runs", nidle, 2);
      tick();

      // 5b: extra start pulses while busy and during done are ignored
      set_start(0, 1'b1);
      ndone = 0; nidle = 0;
      for (int c = 1; c <= 14; c++) begin
         tick();
         set_start(0, (c == 3 || c == 7 || c == 9) ? 1'b1 : 1'b0);
         @(negedge clk);
         if (done0) begin
            ndone++;
            chk("t5b done cycle", c, 9);
         end
         if (c >= 10 && busy0) nidle++;
      end
      set_start(0, 1'b0);
      chk("t5b done count", ndone, 1);
      chk("t5b busy after run", nidle, 0);
      tick();

      // 6: 3-input AND, SETTLE=3
      gsel1 = 0;
      run(1, 100, 1'b0, cyc);
      chk("t6 done cycle", cyc, 33);
      chk("t6 pass", cap_pass, 1);
      chk("t6 err_cnt", cap_err, 0);
      gsel1 = 1;
      run(1, 100, 1'b0, cyc);
      chk("t6b err_cnt", cap_err, 6);
      chk("t6b first_err_vec", cap_fvec, 1);
      chk("t6b pass", cap_pass, 0);

      repeat (3) tick();
      $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
      $finish;
   end

endmodule
